// File: rtl/cla_byte_seq_adder.sv
// Byte-serial multi-precision adder: streams wide operands LSB-first through an external cla_8bit
// stage and reassembles the wide sum/carry. Optional subtract mode under `CLA_SEQ_SUB_EN.
module cla_byte_seq_adder #(
  parameter int unsigned NBYTES = 4,
  localparam int unsigned W = 8 * NBYTES,
  localparam int unsigned IW = $clog2(NBYTES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [7:0]   cla_a,
  output logic [7:0]   cla_b,
  output logic         cla_cin,
  input  logic [7:0]   cla_sum,
  input  logic         cla_cout
`ifdef CLA_SEQ_SUB_EN
  ,
  input  logic         sub
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_nxt;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic [W-1:0]   sum_fin;
  logic [W-1:0]   b_eff;
  logic           cin_eff;

  // Subtraction is A + ~B + 1: invert B at capture and force the initial carry.
  always_comb begin
    b_eff   = b;
    cin_eff = cin;
`ifdef CLA_SEQ_SUB_EN
    if (sub) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end
`endif
  end

  // Final sum with the byte currently leaving cla_8bit merged in.
  always_comb begin
    sum_fin              = sum_q;
    sum_fin[8*idx +: 8]  = cla_sum;
    idx_nxt              = idx + IW'(1);
  end

  // cla_cin doubles as the running inter-byte carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      cla_a     <= '0;
      cla_b     <= '0;
      cla_cin   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b_eff;
            sum_q    <= '0;
            idx      <= '0;
            cla_a    <= a[7:0];
            cla_b    <= b_eff[7:0];
            cla_cin  <= cin_eff;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q[8*idx +: 8] <= cla_sum;
          if (idx == IW'(NBYTES - 1)) begin
            sum       <= sum_fin;
            cout      <= cla_cout;
            out_valid <= 1'b1;
            cla_a     <= '0;
            cla_b     <= '0;
            cla_cin   <= 1'b0;
            state     <= DONE;
          end else begin
            idx     <= idx_nxt;
            cla_a   <= 8'(a_q >> {idx_nxt, 3'b000});
            cla_b   <= 8'(b_q >> {idx_nxt, 3'b000});
            cla_cin <= cla_cout;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_byte_seq_adder.sv
// Self-checking bench for cla_byte_seq_adder (NBYTES=4) with a behavioural cla_8bit stage.
module tb_cla_byte_seq_adder;
  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic [7:0]   cla_a, cla_b, cla_sum;
  logic         cla_cin, cla_cout;
`ifdef CLA_SEQ_SUB_EN
  logic         sub = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External 8-bit stage modelled as plain arithmetic.
  assign {cla_cout, cla_sum} = 9'(cla_a) + 9'(cla_b) + 9'(cla_cin);

  cla_byte_seq_adder #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout)
`ifdef CLA_SEQ_SUB_EN
    , .sub(sub)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Issue one operation from a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, output logic [W-1:0] rs, output logic rc,
                        output int lat, output logic [3:0] cins);
    bit acc = 0;
    rs = '0; rc = 1'b0; lat = -1; cins = '0;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    sub = ts;
`endif
    for (int i = 0; i < 20 && !acc; i++) begin
      if (in_ready) acc = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
    sub = ~ts;
`endif
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    for (int k = 1; k <= 20; k++) begin
      if (k <= 4) cins[k-1] = cla_cin;
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("out_valid_timeout", 0, 1);
    rs = sum; rc = cout;
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         ec;
    logic [3:0]   ecins;
  } vec_t;

  initial begin
    vec_t         tbl[7];
    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    logic [3:0]   cins;
    logic [32:0]  m;
    bit           seen;

    tbl[0] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 4'b0000};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 4'b1111};
    tbl[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 4'b0000};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 4'b1111};
    tbl[4] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 4'b0000};
    tbl[5] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 4'b0000};
    tbl[6] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 4'b1110};

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_sum", 64'(sum), 0);
    chk("rst_cout", 64'(cout), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 1);

    foreach (tbl[i]) begin
      run_op(tbl[i].va, tbl[i].vb, tbl[i].vc, 1'b0, rs, rc, lat, cins);
      chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(tbl[i].es));
      chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(tbl[i].ec));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 4);
      chk($sformatf("vec%0d_cla_cin", i), 64'(cins), 64'(tbl[i].ecins));
      @(negedge clk);
      chk($sformatf("vec%0d_ov_drop", i), 64'(out_valid), 0);
    end

    // Backpressure: result held while out_ready is low, new operands refused.
    out_ready = 1'b0;
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, rs, rc, lat, cins);
    in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h01010101;
    repeat (5) begin
      chk("bp_out_valid", 64'(out_valid), 1);
      chk("bp_sum", 64'(sum), 0);
      chk("bp_cout", 64'(cout), 1);
      chk("bp_in_ready", 64'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_ov", 64'(out_valid), 0);
    chk("bp_release_ir", 64'(in_ready), 1);

    // Reset in mid-RUN drops the operation.
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (in_ready) seen = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_sum", 64'(sum), 0);
    chk("midrst_cla_a", 64'(cla_a), 0);
    seen = 0;
    repeat (10) begin
      if (out_valid) seen = 1;
      @(negedge clk);
    end
    chk("midrst_no_output", 64'(seen), 0);
    run_op(32'h1, 32'h1, 1'b0, 1'b0, rs, rc, lat, cins);
    chk("post_rst_sum", 64'(rs), 2);
    chk("post_rst_cout", 64'(rc), 0);
    @(negedge clk);

`ifdef CLA_SEQ_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, rs, rc, lat, cins);
    chk("sub_5m7_sum", 64'(rs), 64'(32'hFFFFFFFE));
    chk("sub_5m7_cout", 64'(rc), 0);
    @(negedge clk);
    run_op(32'd7, 32'd5, 1'b0, 1'b1, rs, rc, lat, cins);
    chk("sub_7m5_sum", 64'(rs), 2);
    chk("sub_7m5_cout", 64'(rc), 1);
    @(negedge clk);
`endif

    // Randomized operations against an arithmetic reference.
    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] ra, rb;
      logic         rcin, rsub;
      ra = $urandom; rb = $urandom; rcin = 1'($urandom); rsub = 1'b0;
      if (n % 5 == 0) rb = ~ra;
`ifdef CLA_SEQ_SUB_EN
      rsub = 1'($urandom);
`endif
      if (rsub) m = {1'b0, ra} + {1'b0, ~rb} + 33'd1;
      else      m = {1'b0, ra} + {1'b0, rb} + 33'(rcin);
      run_op(ra, rb, rcin, rsub, rs, rc, lat, cins);
      chk($sformatf("rand%0d_sum", n), 64'(rs), 64'(m[W-1:0]));
      chk($sformatf("rand%0d_cout", n), 64'(rc), 64'(m[W]));
      chk($sformatf("rand%0d_latency", n), 64'(lat), 4);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
